// File: rtl/node_segment_streamer_pkg.sv
// Shared definitions for the node segment streamer.
// State encoding and the flattened-bus slice offset helper.
package node_segment_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // Bit offset of node n on a bus whose nodes are width-1 bits wide
    function automatic int slice_base(input int width, input int n);
        return (width - 1) * n;
    endfunction

endpackage

// File: rtl/node_snapshot_bank.sv
// Snapshot register file for every node position in the chain.
// Parallel load from the flattened buses, two combinational read ports.
module node_snapshot_bank
    import node_segment_streamer_pkg::*;
#(
    parameter int width = 32,
    parameter int nodes = 20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [(width-1)*nodes-1:0]     nodes_x,
    input  logic [(width-1)*nodes-1:0]     nodes_y,
    input  logic [$clog2(nodes)-1:0]       index,
    output logic [width-2:0]               x0,
    output logic [width-2:0]               y0,
    output logic [width-2:0]               x1,
    output logic [width-2:0]               y1
);
    localparam int dw = width - 1;
    localparam int iw = $clog2(nodes);

    logic [dw-1:0] snap_x [nodes];
    logic [dw-1:0] snap_y [nodes];
    logic [iw-1:0] next_index;

    assign next_index = index + iw'(1);

    // Capture every node slice of both buses in one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < nodes; n++) begin
                snap_x[n] <= '0;
                snap_y[n] <= '0;
            end
        end else if (load) begin
            for (int n = 0; n < nodes; n++) begin
                snap_x[n] <= nodes_x[slice_base(width, n) +: dw];
                snap_y[n] <= nodes_y[slice_base(width, n) +: dw];
            end
        end
    end

    // Read the node pair (index, index+1); out-of-range reads give 0
    always_comb begin
        x0 = '0;
        y0 = '0;
        x1 = '0;
        y1 = '0;
        for (int n = 0; n < nodes; n++) begin
            if (index == n[iw-1:0]) begin
                x0 = snap_x[n];
                y0 = snap_y[n];
            end
            if (next_index == n[iw-1:0]) begin
                x1 = snap_x[n];
                y1 = snap_y[n];
            end
        end
    end

endmodule

// File: rtl/node_segment_streamer.sv
// Snapshots all core node-position buses on a frame request and
// streams consecutive node pairs as line segments over valid/ready.
module node_segment_streamer
    import node_segment_streamer_pkg::*;
#(
    parameter int node_contains = 5,
    parameter int core_count    = 4,
    parameter int width         = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          frame_req,
    input  logic [(width-1)*node_contains*core_count-1:0] nodes_x,
    input  logic [(width-1)*node_contains*core_count-1:0] nodes_y,
    output logic [width-2:0]                              seg_x0,
    output logic [width-2:0]                              seg_y0,
    output logic [width-2:0]                              seg_x1,
    output logic [width-2:0]                              seg_y1,
    output logic                                          seg_valid,
    input  logic                                          seg_ready,
    output logic                                          seg_last,
    output logic                                          busy,
    output logic                                          frame_done,
    output logic                                          frame_dropped
);
    localparam int nodes = node_contains * core_count;
    localparam int segs  = nodes - 1;
    localparam int iw    = $clog2(nodes);
    localparam logic [iw-1:0] last_index = iw'(segs - 1);

    if (nodes < 2) begin : g_size_check
        $error("node_segment_streamer needs at least two nodes");
    end

    state_t        state;
    logic [iw-1:0] index;
    logic [iw-1:0] rd_index;
    logic          capture;
    logic          advance;
    logic [width-2:0] rd_x0;
    logic [width-2:0] rd_y0;
    logic [width-2:0] rd_x1;
    logic [width-2:0] rd_y1;

    // A handshake on a non-final segment reads the next pair early so it
    // can be registered on the same edge, giving one segment per cycle
    assign capture  = (state == IDLE) && frame_req;
    assign advance  = (state == SEND) && seg_valid && seg_ready
                      && (index != last_index);
    assign rd_index = advance ? index + iw'(1) : index;

    node_snapshot_bank #(
        .width (width),
        .nodes (nodes)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .load    (capture),
        .nodes_x (nodes_x),
        .nodes_y (nodes_y),
        .index   (rd_index),
        .x0      (rd_x0),
        .y0      (rd_y0),
        .x1      (rd_x1),
        .y1      (rd_y1)
    );

    // Frame FSM with registered segment outputs and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            index         <= '0;
            seg_x0        <= '0;
            seg_y0        <= '0;
            seg_x1        <= '0;
            seg_y1        <= '0;
            seg_valid     <= 1'b0;
            seg_last      <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            frame_dropped <= frame_req && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (frame_req) begin
                        busy  <= 1'b1;
                        index <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    seg_x0    <= rd_x0;
                    seg_y0    <= rd_y0;
                    seg_x1    <= rd_x1;
                    seg_y1    <= rd_y1;
                    seg_valid <= 1'b1;
                    seg_last  <= (index == last_index);
                    state     <= SEND;
                end
                SEND: begin
                    if (seg_valid && seg_ready) begin
                        if (index == last_index) begin
                            seg_valid  <= 1'b0;
                            seg_last   <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            index    <= rd_index;
                            seg_x0   <= rd_x0;
                            seg_y0   <= rd_y0;
                            seg_x1   <= rd_x1;
                            seg_y1   <= rd_y1;
                            seg_last <= (rd_index == last_index);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_segment_streamer.sv
// Self-checking bench for node_segment_streamer.
// Random and patterned frames checked against a node-list model.
module tb_node_segment_streamer;

    localparam int DW = 31;
    localparam int N  = 20;
    localparam int S  = N - 1;
    localparam int N2 = 6;
    localparam int S2 = N2 - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_req = 1'b0;
    logic seg_ready = 1'b0;
    logic [DW*N-1:0] nodes_x = '0;
    logic [DW*N-1:0] nodes_y = '0;
    logic [DW-1:0] seg_x0, seg_y0, seg_x1, seg_y1;
    logic seg_valid, seg_last, busy, frame_done, frame_dropped;

    logic s_req = 1'b0;
    logic s_ready = 1'b0;
    logic [DW*N2-1:0] s_nx = '0;
    logic [DW*N2-1:0] s_ny = '0;
    logic [DW-1:0] s_x0, s_y0, s_x1, s_y1;
    logic s_valid, s_last, s_busy, s_done, s_dropped;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mx [N];
    logic [DW-1:0] my [N];
    logic [DW-1:0] sx [N];
    logic [DW-1:0] sy [N];
    logic [DW-1:0] tx [N2];
    logic [DW-1:0] ty [N2];

    always #5 clk = ~clk;

    node_segment_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .frame_req     (frame_req),
        .nodes_x       (nodes_x),
        .nodes_y       (nodes_y),
        .seg_x0        (seg_x0),
        .seg_y0        (seg_y0),
        .seg_x1        (seg_x1),
        .seg_y1        (seg_y1),
        .seg_valid     (seg_valid),
        .seg_ready     (seg_ready),
        .seg_last      (seg_last),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_dropped (frame_dropped)
    );

    node_segment_streamer #(
        .node_contains (3),
        .core_count    (2),
        .width         (32)
    ) dut_small (
        .clk           (clk),
        .reset         (reset),
        .frame_req     (s_req),
        .nodes_x       (s_nx),
        .nodes_y       (s_ny),
        .seg_x0        (s_x0),
        .seg_y0        (s_y0),
        .seg_x1        (s_x1),
        .seg_y1        (s_y1),
        .seg_valid     (s_valid),
        .seg_ready     (s_ready),
        .seg_last      (s_last),
        .busy          (s_busy),
        .frame_done    (s_done),
        .frame_dropped (s_dropped)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_bus();
        for (int n = 0; n < N; n++) begin
            nodes_x[DW*n +: DW] = mx[n];
            nodes_y[DW*n +: DW] = my[n];
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: 5-cycle stall on seg 3
    task automatic run_frame(input int mode, input bit corrupt,
                             input bit drop);
        int k, cyc, stall, guard;
        bit rdy;
        for (int n = 0; n < N; n++) begin
            mx[n] = (mode == 1) ? DW'($urandom) : DW'(n * 10);
            my[n] = (mode == 1) ? DW'($urandom) : DW'(n * 10 + 1);
            sx[n] = mx[n];
            sy[n] = my[n];
        end
        drive_bus();
        frame_req = 1'b1;
        seg_ready = (mode == 0);
        @(negedge clk);
        cyc = 1;
        frame_req = 1'b0;
        check("busy_after_capture", busy, 1);
        check("valid_after_capture", seg_valid, 0);
        if (corrupt) begin
            for (int n = 0; n < N; n++) begin
                mx[n] = DW'(999);
                my[n] = DW'(999);
            end
            drive_bus();
        end
        @(negedge clk);
        cyc++;
        check("first_valid_latency", seg_valid, 1);
        k = 0;
        stall = 0;
        guard = 0;
        while (k < S && guard < 500) begin
            check("seg_valid", seg_valid, 1);
            check("seg_x0", seg_x0, sx[k]);
            check("seg_y0", seg_y0, sy[k]);
            check("seg_x1", seg_x1, sx[k+1]);
            check("seg_y1", seg_y1, sy[k+1]);
            check("seg_last", seg_last, (k == S - 1));
            check("busy_mid", busy, 1);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = bit'($urandom_range(0, 1));
                default: begin
                    rdy = !(k == 3 && stall < 5);
                    if (!rdy) stall++;
                end
            endcase
            seg_ready = rdy;
            frame_req = drop && rdy && (k == S / 2 || k == S - 1);
            @(negedge clk);
            cyc++;
            guard++;
            check("frame_dropped", frame_dropped, frame_req);
            frame_req = 1'b0;
            if (rdy) k++;
        end
        if (guard >= 500) check("frame_timeout", guard, 0);
        check("frame_done", frame_done, 1);
        check("valid_after_last", seg_valid, 0);
        check("busy_after_last", busy, 0);
        check("last_after_last", seg_last, 0);
        if (mode == 0) check("frame_latency", cyc, S + 2);
        if (mode == 2) check("stall_cycles", stall, 5);
        seg_ready = bit'($urandom_range(0, 1));
        @(negedge clk);
        check("done_pulse_end", frame_done, 0);
        check("idle_no_restart", seg_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        for (int n = 0; n < N; n++) begin
            mx[n] = '0;
            my[n] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_valid", seg_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_last", seg_last, 0);
        check("rst_done", frame_done, 0);
        check("rst_dropped", frame_dropped, 0);
        check("rst_x0", seg_x0, 0);
        check("rst_y1", seg_y1, 0);
        check("rst_small_valid", s_valid, 0);
        reset = 1'b1;
        @(negedge clk);

        run_frame(0, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b0);
        run_frame(1, 1'b1, 1'b0);
        run_frame(0, 1'b0, 1'b1);
        run_frame(1, 1'b0, 1'b1);

        // asynchronous reset while segment 7 is presented
        for (int n = 0; n < N; n++) begin
            mx[n] = DW'($urandom) | DW'(1);
            my[n] = DW'($urandom);
            sx[n] = mx[n];
            sy[n] = my[n];
        end
        drive_bus();
        frame_req = 1'b1;
        seg_ready = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_x0", seg_x0, sx[7]);
        check("pre_rst_valid", seg_valid, 1);
        seg_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", seg_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_last", seg_last, 0);
        check("async_rst_x0", seg_x0, 0);
        @(negedge clk);
        check("rst_no_done", frame_done, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_done", frame_done, 0);
        check("post_rst_valid", seg_valid, 0);
        run_frame(1, 1'b0, 1'b0);

        // two cores of three nodes: segments cross the core boundary
        for (int n = 0; n < N2; n++) begin
            tx[n] = DW'($urandom);
            ty[n] = DW'($urandom);
            s_nx[DW*n +: DW] = tx[n];
            s_ny[DW*n +: DW] = ty[n];
        end
        s_ready = 1'b1;
        s_req = 1'b1;
        @(negedge clk);
        s_req = 1'b0;
        @(negedge clk);
        for (int k = 0; k < S2; k++) begin
            check("small_valid", s_valid, 1);
            check("small_x0", s_x0, tx[k]);
            check("small_y0", s_y0, ty[k]);
            check("small_x1", s_x1, tx[k+1]);
            check("small_y1", s_y1, ty[k+1]);
            check("small_last", s_last, (k == S2 - 1));
            @(negedge clk);
        end
        check("small_done", s_done, 1);
        check("small_no_wrap", s_valid, 0);
        @(negedge clk);
        check("small_idle", s_valid, 0);

        repeat (3) run_frame(1, bit'($urandom_range(0, 1)), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/node_segment_streamer.md
Name: node_segment_streamer

Overview:
- Reader side of the node-position buses that each core publishes, all_nodes_x_position and all_nodes_y_position.
- On a frame request it snapshots the position buses of every core in the chain.
- It then streams consecutive node pairs, one line segment per node pair, to the renderer or line drawer over a valid/ready handshake.
- It decouples the free-running physics update from the slower display side, so no core RAM read port is needed.

Parameters:
- node_contains, 5: nodes per core; same value as each core instance.
- core_count, 4: number of cores concatenated on the input buses, core 0 in the LSBs.
- width, 32: core datapath width. Each node slice on the bus is width-1 bits.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- frame_req, input, 1: one-cycle pulse that requests a new frame snapshot.
- nodes_x, input, (width-1)*node_contains*core_count: concatenated all_nodes_x_position buses. Node n occupies [(width-1)*n +: width-1].
- nodes_y, input, (width-1)*node_contains*core_count: concatenated all_nodes_y_position buses, same layout as nodes_x.
- seg_x0, output, width-1: segment start x (node n).
- seg_y0, output, width-1: segment start y (node n).
- seg_x1, output, width-1: segment end x (node n+1).
- seg_y1, output, width-1: segment end y (node n+1).
- seg_valid, output, 1: segment outputs hold a valid segment.
- seg_ready, input, 1: downstream accepts the segment.
- seg_last, output, 1: the current segment is the final one of the frame.
- busy, output, 1: high from capture through the last accepted segment.
- frame_done, output, 1: one-cycle pulse after the last segment is accepted.
- frame_dropped, output, 1: one-cycle pulse when frame_req arrives while busy.

Behaviour:
- Let N = node_contains*core_count and S = N-1 segments per frame. N >= 2 is enforced at elaboration.
- Reset (asynchronous, active-low):
  - state = IDLE, index = 0.
  - seg_valid, seg_last, busy, frame_done and frame_dropped are all 0.
  - seg_x0, seg_y0, seg_x1 and seg_y1 are all 0.
  - Snapshot registers are 0.
- IDLE: on frame_req, latch nodes_x and nodes_y into the snapshot registers on that clock edge. Then busy=1, index=0, go to LOAD.
- LOAD, 1 cycle:
  - Drive seg_x0/seg_y0 from snapshot[index] and seg_x1/seg_y1 from snapshot[index+1].
  - seg_valid=1; seg_last=(index==S-1).
  - Go to SEND.
- SEND:
  - Segment outputs and seg_last hold stable while seg_valid=1 and seg_ready=0 (AXI-style; valid is never withdrawn).
  - On seg_valid&&seg_ready with index<S-1: index+1, load the next pair on the same edge, seg_valid stays 1. Throughput is one segment per cycle under continuous ready.
  - On seg_valid&&seg_ready with index==S-1: seg_valid=0, seg_last=0, busy=0, frame_done=1 for one cycle, go to IDLE.
- Latency:
  - frame_req to first seg_valid = 2 cycles (capture edge, then LOAD edge).
  - Full frame with seg_ready tied high = S+2 cycles from frame_req to frame_done.
- Segments cross core boundaries: node node_contains-1 of core c pairs with node 0 of core c+1. No segment wraps from node N-1 back to node 0.
- frame_req while busy: ignored, the snapshot is unchanged, frame_dropped pulses for one cycle.
- frame_req in the same cycle as the final handshake: treated as busy, so the request is dropped.
- Snapshot data stays constant from capture to frame_done. Input bus changes mid-frame have no effect.
- seg_ready while seg_valid=0 is ignored.
- Reset asserted mid-frame returns immediately to the reset values. No frame_done is issued.
- All coordinates pass through unchanged (width-1 bits, no sign or scale conversion).
- index width is $clog2(N).

Decomposition:
- Shared package (or include):
  - State encoding localparams: IDLE=2'd0, LOAD=2'd1, SEND=2'd2.
  - Helper function giving the slice base offset (width-1)*n.
- One sub-module, node_snapshot_bank: N-entry register file with a parallel load from the flattened buses and two combinational read ports (index, index+1), following the ram_flatted slicing convention.
- The FSM and handshake stay in node_segment_streamer.

Test Plan:
- Basic frame, defaults (N=20, S=19):
  - Stimulus: node n has x=n*10 and y=n*10+1; seg_ready=1; pulse frame_req.
  - Response: seg_valid rises 2 cycles later; segments are (0,1)->(10,11) through (180,181)->(190,191); seg_last is set only on the 19th; frame_done pulses 21 cycles after frame_req.
- Backpressure:
  - Stimulus: hold seg_ready=0 for 5 cycles on segment 3.
  - Response: outputs stay stable at (30,31)->(40,41) with seg_valid=1 throughout; ordering and total count (19) are unchanged.
- Snapshot isolation:
  - Stimulus: after capture, change every nodes_x/nodes_y value to 999.
  - Response: all 19 streamed segments still carry the captured values.
- Dropped request and boundary:
  - Stimulus: pulse frame_req mid-frame, then again in the same cycle as the final handshake.
  - Response: frame_dropped pulses both times; the next frame starts only after a fresh frame_req in IDLE.
- Core boundary:
  - Stimulus: core_count=2, node_contains=3.
  - Response: 5 segments, including node2(core0)->node0(core1); no segment from node 5 to node 0.
- Asynchronous reset mid-frame:
  - Stimulus: assert reset between clock edges during segment 7.
  - Response: seg_valid, busy and seg_last drop immediately; there is no frame_done; a new frame_req after release streams from segment 0.
